commit_trace_packer: RTL and testbench
======================================

# commit_trace_packer

Hardware producer of the retirement trace stream. Samples the writeback/memory-stage commit signals of `cpu` once per cycle and converts them into ordered trace records: REG, LOAD, STORE, HALT. Records are buffered in an internal FIFO and drained over a valid/ready stream to a trace sink (UART/JTAG bridge or bench). It is the on-chip counterpart of the simulation trace monitor and keeps that monitor's record ordering and instruction/cycle counting rules.

## Interface
- `DEPTH`, 8 — FIFO entries; power of two, minimum 4.
- `clk` in 1 — clock; all state updates on rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `reg_write` in 1 — register file write this cycle.
- `wr_reg` in 4 — register written.
- `wr_data` in 16 — register write data.
- `mem_read` in 1 — data memory read this cycle.
- `mem_write` in 1 — data memory write this cycle.
- `mem_addr` in 16 — memory address.
- `mem_wdata` in 16 — data written to memory.
- `mem_rdata` in 16 — data read from memory.
- `hlt` in 1 — halt in memory/writeback stage.
- `trc_valid` out 1 — record available.
- `trc_ready` in 1 — sink accepts the record.
- `trc_type` out 2 — 0 REG, 1 LOAD, 2 STORE, 3 HALT.
- `trc_a` out 16 — REG: `{12'b0, wr_reg}`; LOAD/STORE: `mem_addr`; HALT: `inst_count[15:0]`.
- `trc_b` out 16 — REG: `wr_data`; LOAD: `mem_rdata`; STORE: `mem_wdata`; HALT: `cycle_count[15:0]`.
- `overflow` out 1 — sticky; at least one cycle's events were dropped.
- `drop_count` out 8 — cycles dropped, saturating at 255.
- `done` out 1 — HALT record has been accepted by the sink.

## Operation
- FSM states: RUN, HALTED, DONE. Reset state is RUN.
- RUN:
  - Every cycle: `cycle_count` (32-bit) increments by 1.
  - Every cycle in which `hlt|reg_write|mem_write` is true: `inst_count` (32-bit) increments by 1.
  - Events this cycle: REG if `reg_write`, LOAD if `mem_read`, STORE if `mem_write`, HALT if `hlt`. That gives 0–4 records.
  - Records are pushed in the fixed order REG, LOAD, STORE, HALT, all in the same cycle (multi-write FIFO).
- HALT record fields use the counter values after this cycle's increments, i.e. they include the halt cycle.
- Space check:
  - free = `DEPTH - count`, computed before this cycle's pop; a pop in the same cycle gives no credit.
  - If the number of records exceeds free, all of this cycle's records are dropped (no partial push), `overflow` is set, and `drop_count` increments.
  - Counters still update on a dropped cycle.
  - A dropped HALT still moves the FSM to HALTED.
- Any `hlt`, pushed or dropped, moves RUN to HALTED.
- HALTED:
  - Inputs are ignored and counters freeze.
  - The FIFO drains.
  - When the HALT record completes its handshake, go to DONE. If HALT was dropped, go to DONE when the FIFO is empty.
- DONE: `done`=1, `trc_valid`=0. Leave only by reset.
- Stream rule:
  - A record transfers when `trc_valid & trc_ready`.
  - While `trc_valid`=1 and `trc_ready`=0, `trc_type`, `trc_a` and `trc_b` hold stable.
  - `trc_valid` never drops without a transfer, except on reset.
- Pointers are `log2(DEPTH)+1` bits and wrap modulo 2·DEPTH. Full is `count==DEPTH`; empty is `count==0`.
- Reset mid-operation: FIFO contents discarded; counters, FSM, `overflow`, `drop_count`, `done` cleared immediately (asynchronous).

## Timing
- Reset values: `trc_valid`=0, `trc_type`=0, `trc_a`=0, `trc_b`=0, `overflow`=0, `drop_count`=0, `done`=0; internal counters 0; FSM RUN.
- Events sampled at rising edge N appear on `trc_*` after edge N with `trc_valid`=1, provided the FIFO was empty. Latency is 1 cycle.
- Throughput: 1 record popped per cycle with `trc_ready` held high.
- Output data comes from a registered FIFO head; no combinational path from commit inputs to `trc_*`.
- `trc_ready` may combinationally depend on nothing from this block other than `trc_valid`.
- `done` rises the cycle after the edge where the HALT handshake completes.
- Simultaneous push and pop: both occur; `count` ends at `count + pushed - 1`.

## Test plan
- Reset release, `trc_ready`=1. Drive: `reg_write`, `wr_reg`=3, `wr_data`=0x1234 in cycles 1–2; `hlt` in cycle 3.
  - Required: REG(0x0003, 0x1234) ×2, then HALT(0x0003, 0x0003); `done`=1 after the HALT handshake.
- Single cycle with `reg_write` (r5=0x00AA) and `mem_write` (addr 0x0010, data 0xBEEF).
  - Required: REG(0x0005, 0x00AA), then STORE(0x0010, 0xBEEF), in consecutive cycles.
- `trc_ready`=0 for 5 cycles with a LOAD (0x0020→0x5555) pending.
  - Required: `trc_valid`=1 and LOAD(0x0020, 0x5555) stable for all 5 cycles; transfers on the first ready cycle.
- DEPTH=8, `trc_ready`=0. Drive 7 REG-only cycles, then a cycle with REG+LOAD.
  - Required: the 2-record cycle is dropped entirely; `overflow`=1, `drop_count`=1; 7 records later drain intact.
- Assert `rst_n`=0 mid-stream with 4 records queued.
  - Required: `trc_valid`=0 and all outputs at reset values during reset; no stale records after release.
- After `done`=1, toggle `reg_write` and `mem_write`.
  - Required: no further records, `trc_valid` stays 0.

Source files
------------

// File: rtl/commit_trace_packer.sv
// Retirement trace producer: turns per-cycle commit signals into REG/LOAD/STORE/HALT
// records, buffers them in a multi-write FIFO and drains them over a valid/ready stream.

package commit_trace_packer_pkg;
    typedef enum logic [1:0] {
        REC_REG   = 2'd0,
        REC_LOAD  = 2'd1,
        REC_STORE = 2'd2,
        REC_HALT  = 2'd3
    } rec_type_e;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] b;
    } trace_rec_t;
endpackage

module commit_trace_packer
    import commit_trace_packer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_write,
    input  logic [3:0]  wr_reg,
    input  logic [15:0] wr_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        hlt,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [1:0]  trc_type,
    output logic [15:0] trc_a,
    output logic [15:0] trc_b,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output logic        done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    trace_rec_t      mem_q [DEPTH];
    trace_rec_t      mem_d [DEPTH];
    logic [CW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [31:0]     cyc_q, cyc_d, inst_q, inst_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drop_q, drop_d;
    logic            done_q, done_d;
    logic            halt_drop_q, halt_drop_d;
    logic            valid_q, valid_d;
    trace_rec_t      out_q, out_d;

    logic            pop;
    logic [CW-1:0]   count, free, count_d;
    logic [31:0]     cyc_inc, inst_inc;
    logic [3:0]      ev;
    logic [2:0]      n;
    trace_rec_t      recs    [4];
    trace_rec_t      new_rec [4];

    // Next-state: event packing, space check, FIFO pointers, FSM and output head
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        cyc_d       = cyc_q;
        inst_d      = inst_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        halt_drop_d = halt_drop_q;

        pop      = valid_q & trc_ready;
        count    = wr_q - rd_q;
        free     = CW'(DEPTH) - count;
        cyc_inc  = cyc_q + 32'd1;
        inst_inc = inst_q + 32'(hlt | reg_write | mem_write);
        ev       = {hlt, mem_write, mem_read, reg_write};

        recs[0] = '{kind: REC_REG,   a: {12'b0, wr_reg}, b: wr_data};
        recs[1] = '{kind: REC_LOAD,  a: mem_addr,        b: mem_rdata};
        recs[2] = '{kind: REC_STORE, a: mem_addr,        b: mem_wdata};
        recs[3] = '{kind: REC_HALT,  a: inst_inc[15:0],  b: cyc_inc[15:0]};

        // Compact present events into slots 0..n-1 keeping REG, LOAD, STORE, HALT order
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            new_rec[k] = '0;
        end
        for (int e = 0; e < 4; e++) begin
            if (ev[e]) begin
                new_rec[n[1:0]] = recs[e];
                n = n + 3'd1;
            end
        end

        if (pop) begin
            rd_d = rd_q + CW'(1);
        end

        case (state_q)
            ST_RUN: begin
                cyc_d  = cyc_inc;
                inst_d = inst_inc;
                if (n != 3'd0) begin
                    if (CW'(n) > free) begin
                        ovf_d = 1'b1;
                        if (drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end
                    end else begin
                        for (int k = 0; k < 4; k++) begin
                            if (3'(k) < n) begin
                                mem_d[wr_q[AW-1:0] + AW'(k)] = new_rec[k];
                            end
                        end
                        wr_d = wr_q + CW'(n);
                    end
                end
                if (hlt) begin
                    state_d     = ST_HALTED;
                    halt_drop_d = (CW'(n) > free);
                end
            end
            ST_HALTED: begin
                if (pop && (out_q.kind == REC_HALT)) begin
                    state_d = ST_DONE;
                end else if (halt_drop_q && (count == '0)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
            end
        endcase

        count_d = wr_d - rd_d;
        valid_d = (count_d != '0) && (state_d != ST_DONE);
        out_d   = mem_d[rd_d[AW-1:0]];
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q        <= '0;
            rd_q        <= '0;
            cyc_q       <= '0;
            inst_q      <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
            done_q      <= 1'b0;
            halt_drop_q <= 1'b0;
            valid_q     <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cyc_q       <= cyc_d;
            inst_q      <= inst_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            done_q      <= done_d;
            halt_drop_q <= halt_drop_d;
            valid_q     <= valid_d;
            out_q       <= out_d;
        end
    end

    assign trc_valid  = valid_q;
    assign trc_type   = out_q.kind;
    assign trc_a      = out_q.a;
    assign trc_b      = out_q.b;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
    assign done       = done_q;

endmodule

// File: tb/tb_commit_trace_packer.sv
// Scoreboard bench for commit_trace_packer: a reference model queues expected records,
// a negedge monitor checks every handshake, stream stability, done and drop status.

module tb_commit_trace_packer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_write, mem_read, mem_write, hlt, trc_ready;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data, mem_addr, mem_wdata, mem_rdata;
    logic        trc_valid, overflow, done;
    logic [1:0]  trc_type;
    logic [15:0] trc_a, trc_b;
    logic [7:0]  drop_count;

    commit_trace_packer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_write(reg_write), .wr_reg(wr_reg), .wr_data(wr_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_type(trc_type),
        .trc_a(trc_a), .trc_b(trc_b), .overflow(overflow),
        .drop_count(drop_count), .done(done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] exp_q[$];
    logic        pend_pop = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_ovf  = 1'b0;
    logic [7:0]  exp_drop = 8'd0;
    logic        m_halted = 1'b0;
    logic [31:0] m_cyc = 0, m_inst = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write = 0; mem_read = 0; mem_write = 0; hlt = 0;
        wr_reg = 0; wr_data = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !trc_valid) break;
            tick();
        end
        chk("drain_empty", 36'(exp_q.size() == 0 && !trc_valid), 36'd1);
    endtask

    // Reference model: record list per retirement cycle, whole-cycle drop on lack of space
    initial begin
        forever begin
            logic [33:0] recs[$];
            int          occ;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                pend_pop = 0; exp_ovf = 0; exp_drop = 0;
                m_halted = 0; m_cyc = 0; m_inst = 0;
            end else begin
                occ = exp_q.size() + int'(pend_pop);
                pend_pop = 0;
                if (!m_halted) begin
                    m_cyc++;
                    if (hlt || reg_write || mem_write) m_inst++;
                    recs.delete();
                    if (reg_write) recs.push_back({2'd0, 12'd0, wr_reg, wr_data});
                    if (mem_read)  recs.push_back({2'd1, mem_addr, mem_rdata});
                    if (mem_write) recs.push_back({2'd2, mem_addr, mem_wdata});
                    if (hlt)       recs.push_back({2'd3, m_inst[15:0], m_cyc[15:0]});
                    if (recs.size() > DEPTH - occ) begin
                        exp_ovf = 1;
                        if (exp_drop != 8'hFF) exp_drop++;
                    end else begin
                        foreach (recs[i]) exp_q.push_back(recs[i]);
                    end
                    if (hlt) m_halted = 1;
                end
            end
        end
    end

    // Monitor: handshakes, hold stability, done and drop status
    initial begin
        logic        held = 0;
        logic [33:0] held_rec = '0;
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 0;
                exp_done = 0;
            end else begin
                chk("done", 36'(done), 36'(exp_done));
                chk("overflow", 36'(overflow), 36'(exp_ovf));
                chk("drop_count", 36'(drop_count), 36'(exp_drop));
                if (held) begin
                    chk("hold_valid", 36'(trc_valid), 36'd1);
                    chk("hold_data", 36'({trc_type, trc_a, trc_b}), 36'(held_rec));
                end
                if (trc_valid) begin
                    chk("valid_expected", 36'(exp_q.size() != 0), 36'd1);
                    if (trc_ready && exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("record", 36'({trc_type, trc_a, trc_b}), 36'(e));
                        if (e[33:32] == 2'd3) exp_done = 1;
                        pend_pop = 1;
                    end
                end
                held = trc_valid && !trc_ready;
                held_rec = {trc_type, trc_a, trc_b};
            end
        end
    end

    initial begin
        idle();
        trc_ready = 1;
        rst_n = 0;
        repeat (3) tick();
        chk("rst_valid", 36'(trc_valid), 36'd0);
        chk("rst_type", 36'(trc_type), 36'd0);
        chk("rst_a", 36'(trc_a), 36'd0);
        chk("rst_b", 36'(trc_b), 36'd0);
        chk("rst_done", 36'(done), 36'd0);

        // Two REG retirements then halt: HALT reports 3 instructions in 3 cycles
        reg_write = 1; wr_reg = 4'd3; wr_data = 16'h1234;
        rst_n = 1;
        tick(); tick();
        idle(); hlt = 1;
        tick();
        idle();
        wait_drain();
        repeat (2) tick();
        chk("done_after_halt", 36'(done), 36'd1);
        for (int i = 0; i < 6; i++) begin
            reg_write = 1'($urandom); mem_write = 1'($urandom);
            wr_reg = 4'($urandom); mem_addr = 16'($urandom);
            tick();
        end
        idle(); tick();
        chk("done_no_valid", 36'(trc_valid), 36'd0);
        chk("done_sticky", 36'(done), 36'd1);

        // REG and STORE from one cycle
        do_reset();
        reg_write = 1; wr_reg = 4'd5; wr_data = 16'h00AA;
        mem_write = 1; mem_addr = 16'h0010; mem_wdata = 16'hBEEF;
        tick(); idle();
        wait_drain();

        // LOAD held under backpressure
        trc_ready = 0;
        mem_read = 1; mem_addr = 16'h0020; mem_rdata = 16'h5555;
        tick(); idle();
        repeat (5) tick();
        chk("bp_valid", 36'(trc_valid), 36'd1);
        chk("bp_record", 36'({trc_type, trc_a, trc_b}), 36'({2'd1, 16'h0020, 16'h5555}));
        trc_ready = 1;
        wait_drain();

        // Seven REGs fill to one free slot; a two-record cycle is dropped whole
        trc_ready = 0;
        for (int i = 0; i < 7; i++) begin
            reg_write = 1; wr_reg = 4'(i); wr_data = 16'($urandom);
            tick();
        end
        reg_write = 1; mem_read = 1; wr_reg = 4'hF; mem_addr = 16'h0040;
        tick(); idle();
        chk("ovf_set", 36'(overflow), 36'd1);
        chk("ovf_drop1", 36'(drop_count), 36'd1);
        trc_ready = 1;
        wait_drain();

        // Random traffic with random backpressure, then a final halt
        for (int i = 0; i < 400; i++) begin
            trc_ready = ($urandom_range(0, 3) != 0);
            reg_write = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            wr_reg = 4'($urandom); wr_data = 16'($urandom);
            mem_addr = 16'($urandom); mem_wdata = 16'($urandom); mem_rdata = 16'($urandom);
            tick();
        end
        idle(); trc_ready = 1;
        wait_drain();
        hlt = 1; tick(); idle();
        wait_drain();
        repeat (2) tick();
        chk("rand_done", 36'(done), 36'd1);

        // Reset with four records queued
        do_reset();
        trc_ready = 0;
        for (int i = 0; i < 4; i++) begin
            reg_write = 1; wr_reg = 4'(i); wr_data = 16'($urandom);
            tick();
        end
        idle(); tick();
        chk("pre_reset_valid", 36'(trc_valid), 36'd1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", 36'(trc_valid), 36'd0);
        chk("mid_rst_data", 36'({trc_type, trc_a, trc_b}), 36'd0);
        chk("mid_rst_status", 36'({overflow, drop_count, done}), 36'd0);
        tick();
        rst_n = 1; trc_ready = 1;
        repeat (10) tick();
        chk("post_rst_valid", 36'(trc_valid), 36'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
